// File: rtl/led_pattern_decode.sv
// led_pattern_decode: classifies two observed LED waveforms per tick window and confirms the blink state after two matching windows
//    clk       system clock, all logic on the rising edge
//    rst       synchronous active-high reset
//    tick_lf   one-clk low-frequency strobe; WINDOW_TICKS of them form one window
//    led_a/b   observed LED levels, synchronous to clk
//    state_out last confirmed state (00 off, 01 A blinks, 10 B blinks, 11 B follows A)
//    valid     one-clk pulse when a window confirms state_out
//    changed   one-clk pulse with valid when state_out takes a new value
//    err       one-clk pulse when a closing window matches no pattern
//    locked    high once any state has been confirmed since reset
module led_pattern_decode #(
   parameter int WINDOW_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_lf,
   input  logic       led_a,
   input  logic       led_b,
   output logic [1:0] state_out,
   output logic       valid,
   output logic       changed,
   output logic       err,
   output logic       locked
);
   logic       a_q, b_q;
   logic       a_tog_q, b_tog_q, a_hi_q, b_hi_q, follow_q;
   logic       a_tog_d, b_tog_d, a_hi_d, b_hi_d, follow_d;
   logic [7:0] cnt_q;
   logic [1:0] cand_q, cls;
   logic       cand_ok_q, close, is00, is01, is10, is11, cls_ok, confirm;
   // Flags including the current sample, so the closing cycle is part of its own window
   always_comb begin
      a_tog_d  = a_tog_q | (led_a ^ a_q);
      b_tog_d  = b_tog_q | (led_b ^ b_q);
      a_hi_d   = a_hi_q | led_a;
      b_hi_d   = b_hi_q | led_b;
      follow_d = follow_q & (led_b == a_q);
      close    = tick_lf && (cnt_q == 8'(WINDOW_TICKS - 1));
      is00     = !a_tog_d & !b_tog_d & !a_hi_d & !b_hi_d;
      is01     = a_tog_d & !b_tog_d & !b_hi_d;
      is10     = b_tog_d & !a_tog_d & !a_hi_d;
      is11     = a_tog_d & b_tog_d & follow_d;
      cls      = is00 ? 2'b00 : is01 ? 2'b01 : is10 ? 2'b10 : 2'b11;
      cls_ok   = is00 | is01 | is10 | is11;
      confirm  = cls_ok & cand_ok_q & (cls == cand_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         a_tog_q   <= 1'b0;
         b_tog_q   <= 1'b0;
         a_hi_q    <= 1'b0;
         b_hi_q    <= 1'b0;
         follow_q  <= 1'b1;
         cnt_q     <= 8'd0;
         cand_q    <= 2'b00;
         cand_ok_q <= 1'b0;
         state_out <= 2'b00;
         valid     <= 1'b0;
         changed   <= 1'b0;
         err       <= 1'b0;
         locked    <= 1'b0;
      end else begin
         a_q     <= led_a;
         b_q     <= led_b;
         valid   <= 1'b0;
         changed <= 1'b0;
         err     <= 1'b0;
         if (tick_lf) cnt_q <= close ? 8'd0 : cnt_q + 8'd1;
         if (close) begin
            a_tog_q  <= 1'b0;
            b_tog_q  <= 1'b0;
            a_hi_q   <= 1'b0;
            b_hi_q   <= 1'b0;
            follow_q <= 1'b1;
            if (!cls_ok) begin
               err       <= 1'b1;
               cand_ok_q <= 1'b0;
            end else if (confirm) begin
               state_out <= cls;
               valid     <= 1'b1;
               locked    <= 1'b1;
               changed   <= cls != state_out;
            end else begin
               cand_q    <= cls;
               cand_ok_q <= 1'b1;
            end
         end else begin
            a_tog_q  <= a_tog_d;
            b_tog_q  <= b_tog_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            follow_q <= follow_d;
         end
      end
   end
endmodule

// File: tb/tb_led_pattern_decode.sv
// tb_led_pattern_decode: directed self-checking bench for led_pattern_decode
module tb_led_pattern_decode;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_lf = 1'b0;
   logic       led_a = 1'b0;
   logic       led_b = 1'b0;
   logic [1:0] state_out;
   logic       valid, changed, err, locked;
   int         checks = 0;
   int         errors = 0;
   led_pattern_decode #(.WINDOW_TICKS(4)) dut (
      .clk(clk), .rst(rst), .tick_lf(tick_lf), .led_a(led_a), .led_b(led_b),
      .state_out(state_out), .valid(valid), .changed(changed), .err(err), .locked(locked)
   );
   always #5 clk = ~clk;
   // Outputs packed as {state_out, valid, changed, err, locked}
   function automatic logic [5:0] obs();
      return {state_out, valid, changed, err, locked};
   endfunction
   task automatic step(input logic t);
      tick_lf = t;
      @(posedge clk);
      #1;
   endtask
   // One cycle of a pattern: A/B toggle at the start of each 8-clk tick period; 11 makes B follow A by one clk
   task automatic drive(input logic [1:0] pat, input int i, input logic bad);
      logic tog, nb;
      tog = (i % 8) == 0;
      nb  = led_a ^ bad;
      case (pat)
         2'b00: begin led_a = 1'b0; led_b = 1'b0; end
         2'b01: begin if (tog) led_a = ~led_a; led_b = 1'b0; end
         2'b10: begin led_a = 1'b0; if (tog) led_b = ~led_b; end
         default: begin if (tog) led_a = ~led_a; led_b = nb; end
      endcase
   endtask
   // A full 32-clk window (ticks at 7,15,23,31); pattern p0 before cycle sw, p1 from sw; B forced wrong at cycle bad
   task automatic run_window(input logic [1:0] p0, input logic [1:0] p1, input int sw, input int bad, input string nm);
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < 32; i++) begin
         drive(i < sw ? p0 : p1, i, i == bad);
         step((i % 8) == 7);
         if (i < 31 && (valid | changed | err)) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
         errors++;
         $display("FAIL %s_quiet: got a pulse before the closing tick, expected none", nm);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         led_a = ~led_a;
         led_b = ~led_b;
         step(1'b1);
      end
      checks++;
      if (obs() !== 6'b000000) begin errors++; $display("FAIL reset: got %b expected %b", obs(), 6'b000000); end
      rst = 1'b0;
      led_a = 1'b0;
      led_b = 1'b0;
   endtask
   task automatic test_idle();
      run_window(2'b00, 2'b00, 32, -1, "idle_w1");
      checks++;
      if (obs() !== 6'b000000) begin errors++; $display("FAIL idle_w1: got %b expected %b", obs(), 6'b000000); end
      run_window(2'b00, 2'b00, 32, -1, "idle_w2");
      checks++;
      if (obs() !== 6'b001001) begin errors++; $display("FAIL idle_w2: got %b expected %b", obs(), 6'b001001); end
      drive(2'b00, 0, 1'b0);
      step(1'b0);
      checks++;
      if (obs() !== 6'b000001) begin errors++; $display("FAIL idle_pulse_len: got %b expected %b", obs(), 6'b000001); end
      run_window(2'b00, 2'b00, 32, -1, "idle_w3");
   endtask
   task automatic test_a_only();
      run_window(2'b01, 2'b01, 32, -1, "a_w1");
      checks++;
      if (obs() !== 6'b000001) begin errors++; $display("FAIL a_w1: got %b expected %b", obs(), 6'b000001); end
      run_window(2'b01, 2'b01, 32, -1, "a_w2");
      checks++;
      if (obs() !== 6'b011101) begin errors++; $display("FAIL a_w2: got %b expected %b", obs(), 6'b011101); end
   endtask
   task automatic test_follow();
      run_window(2'b11, 2'b11, 32, -1, "fol_w1");
      checks++;
      if (obs() !== 6'b010001) begin errors++; $display("FAIL fol_w1: got %b expected %b", obs(), 6'b010001); end
      run_window(2'b11, 2'b11, 32, -1, "fol_w2");
      checks++;
      if (obs() !== 6'b111101) begin errors++; $display("FAIL fol_w2: got %b expected %b", obs(), 6'b111101); end
      run_window(2'b11, 2'b11, 32, 20, "fol_bad");
      checks++;
      if (obs() !== 6'b110011) begin errors++; $display("FAIL fol_bad: got %b expected %b", obs(), 6'b110011); end
      run_window(2'b11, 2'b11, 32, -1, "fol_c1");
      checks++;
      if (obs() !== 6'b110001) begin errors++; $display("FAIL fol_c1: got %b expected %b", obs(), 6'b110001); end
      run_window(2'b11, 2'b11, 32, -1, "fol_c2");
      checks++;
      if (obs() !== 6'b111001) begin errors++; $display("FAIL fol_c2: got %b expected %b", obs(), 6'b111001); end
      drive(2'b11, 0, 1'b0);
      step(1'b0);
      checks++;
      if (obs() !== 6'b110001) begin errors++; $display("FAIL fol_pulse_len: got %b expected %b", obs(), 6'b110001); end
      for (int i = 1; i < 32; i++) begin
         drive(2'b11, i, 1'b0);
         step((i % 8) == 7);
      end
   endtask
   task automatic test_switch();
      run_window(2'b01, 2'b01, 32, -1, "sw_a1");
      checks++;
      if (obs() !== 6'b110001) begin errors++; $display("FAIL sw_a1: got %b expected %b", obs(), 6'b110001); end
      run_window(2'b01, 2'b01, 32, -1, "sw_a2");
      checks++;
      if (obs() !== 6'b011101) begin errors++; $display("FAIL sw_a2: got %b expected %b", obs(), 6'b011101); end
      run_window(2'b01, 2'b10, 16, -1, "sw_mix");
      checks++;
      if (obs() !== 6'b010011) begin errors++; $display("FAIL sw_mix: got %b expected %b", obs(), 6'b010011); end
      run_window(2'b10, 2'b10, 32, -1, "sw_b1");
      checks++;
      if (obs() !== 6'b010001) begin errors++; $display("FAIL sw_b1: got %b expected %b", obs(), 6'b010001); end
      run_window(2'b10, 2'b10, 32, -1, "sw_b2");
      checks++;
      if (obs() !== 6'b101101) begin errors++; $display("FAIL sw_b2: got %b expected %b", obs(), 6'b101101); end
   endtask
   task automatic test_mid_reset();
      for (int i = 0; i < 20; i++) begin
         drive(2'b10, i, 1'b0);
         step((i % 8) == 7);
      end
      rst = 1'b1;
      led_a = 1'b0;
      led_b = 1'b0;
      step(1'b0);
      checks++;
      if (obs() !== 6'b000000) begin errors++; $display("FAIL mid_rst: got %b expected %b", obs(), 6'b000000); end
      rst = 1'b0;
      run_window(2'b10, 2'b10, 32, -1, "mr_w1");
      checks++;
      if (obs() !== 6'b000000) begin errors++; $display("FAIL mr_w1: got %b expected %b", obs(), 6'b000000); end
      run_window(2'b10, 2'b10, 32, -1, "mr_w2");
      checks++;
      if (obs() !== 6'b101101) begin errors++; $display("FAIL mr_w2: got %b expected %b", obs(), 6'b101101); end
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, i, 1'b0);
         step(1'b1);
      end
      checks++;
      if (obs() !== 6'b100001) begin errors++; $display("FAIL b2b_early: got %b expected %b", obs(), 6'b100001); end
      drive(2'b00, 3, 1'b0);
      step(1'b1);
      checks++;
      if (obs() !== 6'b100001) begin errors++; $display("FAIL b2b_w1: got %b expected %b", obs(), 6'b100001); end
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, i, 1'b0);
         step(1'b1);
      end
      checks++;
      if (obs() !== 6'b001101) begin errors++; $display("FAIL b2b_w2: got %b expected %b", obs(), 6'b001101); end
   endtask
   initial begin
      test_reset();
      test_idle();
      test_a_only();
      test_follow();
      test_switch();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_pattern_decode.md
LED_PATTERN_DECODE -- requirements
Module: led_pattern_decode

Interface
REQ-001 SHALL have parameter WINDOW_TICKS, default 4, meaning tick_lf pulses per observation window; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick_lf  input  1  one-clk low-frequency strobe, same strobe that drives the LED blinker.
REQ-005 SHALL have port led_a  input  1  observed LED A level, synchronous to clk.
REQ-006 SHALL have port led_b  input  1  observed LED B level, synchronous to clk.
REQ-007 SHALL have port state_out  output  2  last confirmed decoded blink state.
REQ-008 SHALL have port valid  output  1  one-clk pulse when a window classification confirms state_out.
REQ-009 SHALL have port changed  output  1  one-clk pulse, coincident with valid, when state_out takes a new value.
REQ-010 SHALL have port err  output  1  one-clk pulse when a closing window matches no pattern.
REQ-011 SHALL have port locked  output  1  level; high once any state has been confirmed since reset.

Function
REQ-012 SHALL register led_a and led_b once per clk (a_d, b_d); a toggle is a cycle where led_x != x_d.
REQ-013 SHALL keep per-window flags: a_tog, b_tog (any toggle), a_hi, b_hi (any high sample), follow_ok (cleared in any cycle where led_b != a_d).
REQ-014 SHALL count tick_lf pulses in tick_cnt (8 bits); the window closes in the cycle where tick_lf=1 and tick_cnt==WINDOW_TICKS-1, and tick_cnt then wraps to 0.
REQ-015 SHALL include the closing cycle's own sample in the closing window; flags SHALL restart (0, follow_ok=1) from the following cycle.
REQ-016 SHALL classify at close: 00 if !a_tog & !b_tog & !a_hi & !b_hi; 01 if a_tog & !b_tog & !b_hi; 10 if b_tog & !a_tog & !a_hi; 11 if a_tog & b_tog & follow_ok; otherwise INVALID.
REQ-017 SHALL hold candidate register cand[1:0] plus cand_ok; a valid class equal to cand with cand_ok=1 is CONFIRMED; a valid class otherwise loads cand and sets cand_ok.
REQ-018 On CONFIRMED: state_out<=class, valid=1, locked=1, changed=1 only if class != previous state_out.
REQ-019 On INVALID: err=1, cand_ok<=0, state_out and locked unchanged.
REQ-020 All outputs SHALL be registered; pulses appear in the cycle after the closing cycle and last exactly one clk.
REQ-021 Minimum latency from a stable pattern to confirmation: two full windows; a window spanning a state change SHALL yield INVALID or a non-confirming candidate, never a wrong confirmation by itself.
REQ-022 tick_lf asserted in consecutive cycles SHALL count each cycle as one tick.

Reset
REQ-023 While rst=1 at a clk edge: state_out=00, valid=changed=err=locked=0, tick_cnt=0, a_d=b_d=0, cand=00, cand_ok=0, flags at initial values.
REQ-024 rst mid-window SHALL discard the partial window; counting restarts at the first tick after rst deasserts.

Verification (WINDOW_TICKS=4, tick_lf every 8 clk)
REQ-025 Reset: rst=1 for 3 clk with LEDs toggling -> all outputs 0, no pulses for 2 windows' worth of ticks with LEDs low apart from the confirmation in REQ-026.
REQ-026 led_a=led_b=0 for 8 ticks -> valid pulse after 2nd close, state_out=00, locked=1, changed=0.
REQ-027 led_a toggles 1 clk after each tick, led_b=0 -> after 2nd close valid=1, changed=1, state_out=01.
REQ-028 led_a toggling, led_b = led_a delayed 1 clk -> state_out=11; then force led_b wrong for 1 clk -> err pulse at that close, state_out stays 11, next two clean windows re-confirm 11 with changed=0.
REQ-029 Switch 01->10 pattern mid-window -> err pulse at that close, state_out holds 01, then 10 confirmed after two clean windows with changed=1.
REQ-030 rst pulsed at tick_cnt=2 while locked at 10 -> state_out=00, locked=0 next cycle; next confirmation needs two complete windows.
